// File: rtl/line_buffer_fwft_reader.sv
// Read-side consumer for the line-buffer FIFO controller.
// Turns the controller's native read port (r_en/rempty, data one cycle after
// the strobe) into a first-word-fall-through valid/ready stream with a
// head + skid buffer, and tags every word with its column/row position and
// line/frame markers.
module line_buffer_fwft_reader #(
  parameter int c_DATA_WIDTH  = 8,
  parameter int c_COL_WIDTH   = 10,
  parameter int c_ROW_WIDTH   = 10,
  parameter int c_LINE_LEN    = 640,
  parameter int c_FRAME_LINES = 480
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic                    fifo_rempty,
  output logic                    fifo_ren,
  input  logic [c_DATA_WIDTH-1:0] fifo_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic [c_COL_WIDTH-1:0]  m_col,
  output logic [c_ROW_WIDTH-1:0]  m_row,
  output logic                    m_last,
  output logic                    m_sof
);

  localparam logic [c_COL_WIDTH-1:0] LAST_COL = c_COL_WIDTH'(c_LINE_LEN - 1);
  localparam logic [c_ROW_WIDTH-1:0] LAST_ROW = c_ROW_WIDTH'(c_FRAME_LINES - 1);

  logic [1:0]              occ;       // words held in head + skid
  logic                    inflight;  // read issued last cycle, data on fifo_rdata now
  logic [c_DATA_WIDTH-1:0] head;
  logic [c_DATA_WIDTH-1:0] skid;
  logic [1:0]              depth;     // occ + inflight, never exceeds 2
  logic                    pop;
  logic                    cap;

  assign pop     = m_valid & m_ready;
  assign cap     = inflight;
  assign depth   = occ + {1'b0, inflight};
  assign m_valid = (occ != 2'd0);
  assign m_data  = head;

  // Issue a read only when the word is guaranteed a slot on return; a pop
  // this cycle frees one, which keeps reads going back-to-back.
  always_comb begin
    fifo_ren = 1'b0;
    if (!rrst && !fifo_rempty)
      fifo_ren = (depth < 2'd2) | ((depth == 2'd2) & pop);
  end

  // Return path: capture the RAM word into head or skid, shift skid on pop.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      skid     <= '0;
    end else begin
      inflight <= fifo_ren;
      occ      <= occ + {1'b0, cap} - {1'b0, pop};
      if (cap) begin
        if (occ == 2'd0 || (pop && occ == 2'd1)) begin
          head <= fifo_rdata;
        end else if (pop && occ == 2'd2) begin
          head <= skid;
          skid <= fifo_rdata;
        end else begin
          skid <= fifo_rdata;
        end
      end else if (pop && occ == 2'd2) begin
        head <= skid;
      end
    end
  end

  // Position counters track the head word and advance on each pop.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      m_col <= '0;
      m_row <= '0;
    end else if (pop) begin
      if (m_col == LAST_COL) begin
        m_col <= '0;
        m_row <= (m_row == LAST_ROW) ? '0 : m_row + 1'b1;
      end else begin
        m_col <= m_col + 1'b1;
      end
    end
  end

  assign m_last = (m_col == LAST_COL);
  assign m_sof  = (m_col == '0) && (m_row == '0);

endmodule

// File: tb/tb_line_buffer_fwft_reader.sv
// Bench for line_buffer_fwft_reader: behavioural FIFO controller, a word-level
// scoreboard with position model, directed tables and a randomized phase.
module tb_line_buffer_fwft_reader;

  localparam int DW    = 8;
  localparam int CW    = 10;
  localparam int RW    = 10;
  localparam int LEN   = 4;
  localparam int LINES = 2;

  logic          rclk = 1'b0;
  logic          rrst = 1'b1;
  logic          fifo_rempty = 1'b1;
  logic          fifo_ren;
  logic [DW-1:0] fifo_rdata = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_col;
  logic [RW-1:0] m_row;
  logic          m_last;
  logic          m_sof;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] q[$];    // words sitting in the controller
  logic [DW-1:0] exp[$];  // words expected at the output, in order
  int k = 0;              // words popped since reset
  int out_n = 0;          // words fetched but not yet popped

  line_buffer_fwft_reader #(
    .c_DATA_WIDTH(DW), .c_COL_WIDTH(CW), .c_ROW_WIDTH(RW),
    .c_LINE_LEN(LEN), .c_FRAME_LINES(LINES)
  ) dut (
    .rclk(rclk), .rrst(rrst),
    .fifo_rempty(fifo_rempty), .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_col(m_col), .m_row(m_row), .m_last(m_last), .m_sof(m_sof)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
    exp.push_back(w);
  endtask

  // Controller read side: data one cycle after r_en, registered empty flag.
  always @(posedge rclk) begin
    if (fifo_ren && q.size() > 0) fifo_rdata <= q.pop_front();
    fifo_rempty <= (q.size() == 0);
  end

  // Scoreboard: order, position markers, read legality and buffer bound.
  always @(negedge rclk) begin
    if (rrst) begin
      k = 0;
      exp = q;
      out_n = 0;
    end
    chk("col", m_col, k % LEN);
    chk("row", m_row, (k / LEN) % LINES);
    chk("last", m_last, (k % LEN) == LEN - 1);
    chk("sof", m_sof, (k % (LEN * LINES)) == 0);
    if (rrst) begin
      chk("ren_in_reset", fifo_ren, 0);
      chk("valid_in_reset", m_valid, 0);
    end else begin
      chk("outstanding_le2", out_n <= 2, 1);
      if (fifo_ren) chk("ren_when_empty", fifo_rempty, 0);
      if (m_valid) begin
        if (exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_word: got %0h expected no word", m_data);
        end else begin
          chk("order", m_data, exp[0]);
        end
        if (m_ready) begin
          if (exp.size() > 0) void'(exp.pop_front());
          k++;
        end
      end
      out_n = out_n + int'(fifo_ren) - int'(m_valid && m_ready);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          rdy;
    logic          ren;
    logic          valid;
    logic [DW-1:0] data;
  } lat_t;

  typedef struct {
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last;
    logic          sof;
  } mk_t;

  lat_t lat[4];
  mk_t  mk[9];

  initial begin
    int idx;
    bit got;

    lat[0] = '{1'b1, 1'b1, 1'b0, 8'h00};
    lat[1] = '{1'b1, 1'b0, 1'b0, 8'h00};
    lat[2] = '{1'b1, 1'b0, 1'b1, 8'hA5};
    lat[3] = '{1'b1, 1'b0, 1'b0, 8'h00};

    mk[0] = '{10'd0, 10'd0, 1'b0, 1'b1};
    mk[1] = '{10'd1, 10'd0, 1'b0, 1'b0};
    mk[2] = '{10'd2, 10'd0, 1'b0, 1'b0};
    mk[3] = '{10'd3, 10'd0, 1'b1, 1'b0};
    mk[4] = '{10'd0, 10'd1, 1'b0, 1'b0};
    mk[5] = '{10'd1, 10'd1, 1'b0, 1'b0};
    mk[6] = '{10'd2, 10'd1, 1'b0, 1'b0};
    mk[7] = '{10'd3, 10'd1, 1'b1, 1'b0};
    mk[8] = '{10'd0, 10'd0, 1'b0, 1'b1};

    // Reset with a non-empty controller: no reads, outputs at reset values.
    push(8'h11);
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("rst_rempty_low", fifo_rempty, 0);
    chk("rst_ren", fifo_ren, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_col", m_col, 0);
    chk("rst_row", m_row, 0);
    chk("rst_sof", m_sof, 1);
    @(posedge rclk); #1 rrst = 1'b0;
    @(negedge rclk);
    chk("rst_release_ren", fifo_ren, 1);
    m_ready = 1'b1;
    repeat (6) @(posedge rclk);

    // Single-word latency.
    #1 push(8'hA5);
    @(posedge rclk);
    for (int c = 0; c < 4; c++) begin
      m_ready = lat[c].rdy;
      @(negedge rclk);
      chk("lat_ren", fifo_ren, lat[c].ren);
      chk("lat_valid", m_valid, lat[c].valid);
      if (lat[c].valid) chk("lat_data", m_data, lat[c].data);
    end
    repeat (3) @(posedge rclk);

    // Streaming: one word per cycle, cycles 2..17.
    #1 for (int i = 0; i < 16; i++) push(DW'(i));
    @(posedge rclk);
    for (int c = 0; c < 19; c++) begin
      @(negedge rclk);
      if (c >= 2 && c <= 17) begin
        chk("stream_valid", m_valid, 1);
        chk("stream_data", m_data, c - 2);
      end else if (c == 18) begin
        chk("stream_end_valid", m_valid, 0);
      end
    end
    repeat (3) @(posedge rclk);

    // Backpressure: ready low in cycles 5..9.
    #1 for (int i = 0; i < 10; i++) push(DW'(i));
    @(posedge rclk);
    for (int c = 0; c < 20; c++) begin
      #1 m_ready = !(c >= 5 && c <= 9);
      @(negedge rclk);
      if (c >= 5 && c <= 9) begin
        chk("bp_ren_off", fifo_ren, 0);
        chk("bp_valid_held", m_valid, 1);
        chk("bp_data_held", m_data, 3);
      end else if (c == 10) begin
        chk("bp_resume_ren", fifo_ren, 1);
        chk("bp_resume_data", m_data, 3);
      end
      @(posedge rclk);
    end
    chk("bp_drained", exp.size(), 0);

    // Markers: fresh reset, 9 words across two lines and a frame wrap.
    #1 rrst = 1'b1;
    @(posedge rclk); #1 rrst = 1'b0;
    for (int i = 0; i < 9; i++) push(DW'(8'h20 + i));
    @(posedge rclk);
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge rclk);
      if (m_valid && idx < 9) begin
        chk("mk_data", m_data, 8'h20 + idx);
        chk("mk_col", m_col, mk[idx].col);
        chk("mk_row", m_row, mk[idx].row);
        chk("mk_last", m_last, mk[idx].last);
        chk("mk_sof", m_sof, mk[idx].sof);
        idx++;
      end
    end
    chk("mk_count", idx, 9);

    // Reset mid-stream while a read is in flight.
    @(posedge rclk);
    #1 for (int i = 0; i < 8; i++) push(DW'(8'h50 + i));
    @(posedge rclk);
    repeat (4) @(negedge rclk);
    #1 rrst = 1'b1;
    q.delete();
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_col", m_col, 0);
    chk("mid_rst_row", m_row, 0);
    chk("mid_rst_sof", m_sof, 1);
    chk("mid_rst_ren", fifo_ren, 0);
    @(posedge rclk);
    @(posedge rclk); #1 rrst = 1'b0;
    for (int i = 0; i < 3; i++) push(DW'(8'h70 + i));
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge rclk);
      if (m_valid) begin
        got = 1'b1;
        chk("mid_rst_first_data", m_data, 8'h70);
        chk("mid_rst_first_col", m_col, 0);
      end
    end
    chk("mid_rst_word_seen", got, 1);
    repeat (6) @(posedge rclk);

    // Randomized traffic and backpressure against the scoreboard.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge rclk);
      #1 m_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0)
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) push(DW'($urandom));
    end

    // Drain everything, bounded.
    @(posedge rclk); #1 m_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge rclk);
      if (exp.size() == 0 && q.size() == 0 && !m_valid) break;
    end
    chk("final_drained", exp.size(), 0);
    chk("final_valid", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
